univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: hold, shift right, shift left and parallel load.

---
 rtl/univ_shift_reg_pkg.sv | 16 +
 rtl/univ_shift_reg_shift_frame_counter.sv | 35 +++
 rtl/univ_shift_reg.sv | 72 +++++++
 tb/tb_univ_shift_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
package univ_shift_reg_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD = 2'b00;
  localparam shift_mode_t MODE_SHR  = 2'b01;
  localparam shift_mode_t MODE_SHL  = 2'b10;
  localparam shift_mode_t MODE_LOAD = 2'b11;

  // Both shift directions (and rotates) advance the frame counter.
  function automatic logic is_shift(shift_mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_frame_counter.sv
// Frame counter: counts shifts modulo WIDTH and pulses frame_done in the
// cycle after the WIDTH-th shift. A restart (parallel load) opens a new frame.
module shift_frame_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             restart,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Count shifts; wrap on the last one of a frame and raise the pulse.
  always_ff @(posedge clk) begin
    if (clear || restart) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (inc) begin
      if (shift_cnt == LAST) begin
        shift_cnt  <= '0;
        frame_done <= 1'b1;
      end else begin
        shift_cnt  <= shift_cnt + CNT_W'(1);
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a frame counter flagging every WIDTH shifts.
// Optional build macro SHIFT_REG_ROTATE_EN adds a rotate input that feeds the
// outgoing bit back in instead of the serial input.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] d,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_next;
  logic             rot;
  logic             inc;
  logic             restart;

`ifdef SHIFT_REG_ROTATE_EN
  assign rot = rotate;
`else
  assign rot = 1'b0;
`endif

  // Next-state mux for the data register.
  always_comb begin
    q_next = q;
    if (en) begin
      case (shift_mode_t'(mode))
        MODE_SHR:  q_next = {(rot ? q[0] : si_r), q[WIDTH-1:1]};
        MODE_SHL:  q_next = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : si_l)};
        MODE_LOAD: q_next = d;
        default:   q_next = q;
      endcase
    end
  end

  // Data register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) q <= '0;
    else       q <= q_next;
  end

  assign so_r    = q[0];
  assign so_l    = q[WIDTH-1];
  assign inc     = en & is_shift(shift_mode_t'(mode));
  assign restart = en & (shift_mode_t'(mode) == MODE_LOAD);

  shift_frame_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk        (clk),
    .clear      (clear),
    .inc        (inc),
    .restart    (restart),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4; plus WIDTH=8 rotate case
// when SHIFT_REG_ROTATE_EN is defined).
module tb_univ_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear, en, si_r, si_l;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         so_r, so_l, frame_done;
  logic [1:0]   shift_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] q;
    int           cnt;
    logic         fd;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] mq;
  int           mcnt;
  logic         mfd;

  always #5 clk = ~clk;

`ifdef SHIFT_REG_ROTATE_EN
  logic rot4 = 1'b0;
`endif

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .clear      (clear),
    .en         (en),
    .mode       (mode),
    .si_r       (si_r),
    .si_l       (si_l),
    .d          (d),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate     (rot4),
`endif
    .q          (q),
    .so_r       (so_r),
    .so_l       (so_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

`ifdef SHIFT_REG_ROTATE_EN
  logic       clear8, en8, rot8;
  logic [1:0] mode8;
  logic [7:0] d8, q8;
  logic       so_r8, so_l8, fd8;
  logic [2:0] cnt8;
  logic [8:0] sb8[$];

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .clear      (clear8),
    .en         (en8),
    .mode       (mode8),
    .si_r       (1'b0),
    .si_l       (1'b0),
    .d          (d8),
    .rotate     (rot8),
    .q          (q8),
    .so_r       (so_r8),
    .so_l       (so_l8),
    .shift_cnt  (cnt8),
    .frame_done (fd8)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, queue its expectation,
  // then pop and compare once the DUT has clocked.
  task automatic step(input logic c, input logic e, input logic [1:0] m,
                      input logic sr, input logic sl, input logic [W-1:0] dd);
    exp_t x;
    clear = c; en = e; mode = m; si_r = sr; si_l = sl; d = dd;
    if (c) begin
      mq = '0; mcnt = 0; mfd = 1'b0;
    end else if (!e || m == 2'b00) begin
      mfd = 1'b0;
    end else if (m == 2'b11) begin
      mq = dd; mcnt = 0; mfd = 1'b0;
    end else begin
      if (m == 2'b01) mq = {sr, mq[W-1:1]};
      else            mq = {mq[W-2:0], sl};
      mcnt = mcnt + 1;
      mfd  = (mcnt == W);
      if (mcnt == W) mcnt = 0;
    end
    x.q = mq; x.cnt = mcnt; x.fd = mfd;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("q",    32'(q),          32'(x.q));
    chk("so_r", 32'(so_r),       32'(x.q[0]));
    chk("so_l", 32'(so_l),       32'(x.q[W-1]));
    chk("cnt",  32'(shift_cnt),  32'(x.cnt));
    chk("fd",   32'(frame_done), 32'(x.fd));
  endtask

`ifdef SHIFT_REG_ROTATE_EN
  task automatic step8(input logic c, input logic [1:0] m, input logic r,
                       input logic [7:0] dd, input logic [8:0] exp);
    logic [8:0] x;
    clear8 = c; en8 = 1'b1; mode8 = m; rot8 = r; d8 = dd;
    sb8.push_back(exp);
    @(posedge clk);
    #1;
    x = sb8.pop_front();
    chk("rot_q",  32'(q8),  32'(x[7:0]));
    chk("rot_fd", 32'(fd8), 32'(x[8]));
  endtask
`endif

  initial begin
    mq = '0; mcnt = 0; mfd = 1'b0;
    clear = 1'b1; en = 1'b1; mode = 2'b11; si_r = 1'b0; si_l = 1'b0; d = 4'hF;

    // Reset dominates en/mode/d
    step(1, 1, 2'b11, 0, 0, 4'hF);
    step(1, 1, 2'b11, 0, 0, 4'hF);
    chk("rst_q",   32'(q),          32'h0);
    chk("rst_cnt", 32'(shift_cnt),  32'h0);
    chk("rst_fd",  32'(frame_done), 32'h0);

    // Serial right 1,0,1,1
    step(0, 1, 2'b01, 1, 0, 4'h0); chk("shr_q1", 32'(q), 32'b1000);
    step(0, 1, 2'b01, 0, 0, 4'h0); chk("shr_q2", 32'(q), 32'b0100);
    step(0, 1, 2'b01, 1, 0, 4'h0); chk("shr_q3", 32'(q), 32'b1010);
    chk("shr_fd3", 32'(frame_done), 32'h0);
    step(0, 1, 2'b01, 1, 0, 4'h0); chk("shr_q4", 32'(q), 32'b1101);
    chk("shr_fd4", 32'(frame_done), 32'h1);
    step(0, 1, 2'b00, 0, 0, 4'h0);
    chk("shr_fd_drop", 32'(frame_done), 32'h0);

    // Load then shift left
    step(0, 1, 2'b11, 0, 0, 4'b1001); chk("ld_q", 32'(q), 32'b1001);
    step(0, 1, 2'b10, 0, 0, 4'h0);    chk("shl_q1", 32'(q), 32'b0010);
    step(0, 1, 2'b10, 0, 0, 4'h0);    chk("shl_q2", 32'(q), 32'b0100);
    chk("shl_sol", 32'(so_l), 32'h0);
    chk("shl_cnt", 32'(shift_cnt), 32'h2);

    // Hold and en gating
    repeat (3) step(0, 1, 2'b00, 1, 1, 4'hF);
    repeat (3) step(0, 0, 2'b01, 1, 1, 4'hF);
    chk("gate_q",   32'(q),         32'b0100);
    chk("gate_cnt", 32'(shift_cnt), 32'h2);
    step(0, 1, 2'b10, 0, 1, 4'h0);
    chk("gate_fd3", 32'(frame_done), 32'h0);
    step(0, 1, 2'b01, 0, 1, 4'h0);
    chk("gate_fd4", 32'(frame_done), 32'h1);

    // Reset mid-frame
    repeat (3) step(0, 1, 2'b01, 1, 0, 4'h0);
    step(1, 1, 2'b01, 1, 0, 4'h0);
    chk("mid_fd_clr", 32'(frame_done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b10, 1, 1, 4'h0);
      chk("mid_fd_none", 32'(frame_done), 32'h0);
    end
    step(0, 1, 2'b10, 1, 1, 4'h0);
    chk("mid_fd", 32'(frame_done), 32'h1);

    // Back-to-back frames: pulse every W cycles
    for (int i = 1; i <= 2 * W; i++) begin
      step(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'($urandom), 1'($urandom), 4'h0);
      chk("b2b_fd", 32'(frame_done), 32'((i % W) == 0));
    end

    // Random mix, model-checked
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    end

`ifdef SHIFT_REG_ROTATE_EN
    step8(1, 2'b11, 1'b0, 8'h00, 9'h000);
    step8(0, 2'b11, 1'b0, 8'hA5, 9'h0A5);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h0D2);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h069);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h0B4);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h05A);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h02D);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h096);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h04B);
    step8(0, 2'b01, 1'b1, 8'h00, 9'h1A5);
    step8(0, 2'b00, 1'b1, 8'h00, 9'h0A5);
    step8(0, 2'b10, 1'b1, 8'h00, 9'h04B);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
